index_scoreboard: RTL and testbench
===================================

Name: index_scoreboard

Overview:
- Binary-index-to-bitmap decoder with state: decodes LogN+1-bit indices into one-hot set/clear operations on a registered N-bit occupancy mask.
- Inverse companion of the priority encoder. The encoder picks a free or pending slot from a bitmap; this block writes indices back into that bitmap.
- Used as a register/tag scoreboard and as a pending-request tracker in front of the FPU issue logic.

Parameters:
- N, 8, number of tracked slots; N >= 2; need not be a power of two.
- LogN, (N == 1 ? 0 : $clog2(N)-1), MSB position of index buses, so indices are LogN+1 bits wide. Derived; do not override.

Ports:
- clock  input  1  rising-edge clock
- reset_n  input  1  asynchronous active-low reset
- set_valid  input  1  request to mark slot set_index busy
- set_index  input  LogN+1  slot to set
- set_ready  output  1  combinational; set accepted this cycle when set_valid & set_ready
- clear_valid  input  1  request to mark slot clear_index free; always accepted
- clear_index  input  LogN+1  slot to clear
- clear_all  input  1  synchronous flush of every slot
- mask  output  N  registered occupancy bitmap; bit i = slot i busy
- count  output  LogN+2  registered population count of mask
- full  output  1  registered; count == N
- empty  output  1  registered; count == 0

Behaviour:
- Reset (reset_n low, asynchronous): mask=0, count=0, empty=1, full=0. Effective immediately and held while low; first update on the first rising edge after release.
- Decode: set_oh = one-hot of set_index; clear_oh = one-hot of clear_index. An index >= N decodes to all-zero.
- set_ready = (set_index < N) & (~mask[set_index] | clear_hit).
  - clear_hit = clear_valid & (clear_index == set_index).
  - Purely combinational from mask and inputs; never depends on set_valid.
- Next mask (one-cycle latency, visible the cycle after the edge):
  - clear_all=1: mask_next = 0. Overrides all other requests; a set in the same cycle is dropped even if set_ready=1.
  - Otherwise: mask_next = (mask & ~(clear_valid ? clear_oh : 0)) | (set_fire ? set_oh : 0), where set_fire = set_valid & set_ready.
- Simultaneous set and clear of the same index: the set wins; the bit stays or becomes 1; count unchanged if the bit was already 1.
- Clear of an already-free slot or an out-of-range index: no effect on mask or count.
- Set of a busy slot without a matching clear: set_ready=0, no state change. The requester must hold set_valid/set_index until ready.
- count_next is computed incrementally, never by recounting:
  - count + set_fire_new − clear_eff.
  - set_fire_new = 1 only if the bit was previously 0.
  - clear_eff = 1 only if the bit was previously 1 and not re-set in the same cycle.
  - clear_all forces count_next = 0.
- full/empty are registered from count_next, so they are always consistent with mask in the same cycle.
- Invariant: count == popcount(mask) in every cycle; count never exceeds N or underflows.

Optional Feature:
- Macro SCOREBOARD_ERR_CHECK_EN.
- Defined: adds output err (1 bit, registered, sticky). It sets on:
  - a clear of a free slot,
  - a clear of an out-of-range index,
  - a set_valid with set_index >= N.
- err is cleared only by reset_n or clear_all; reset value 0. If clear_all and an error event occur in the same cycle, clear_all wins.
- Not defined: port err absent, no extra logic; functional behaviour is otherwise identical.

Test Plan:
- Reset, N=8: assert reset_n=0 mid-run with mask=8'hA5 -> mask=0, count=0, empty=1, full=0 immediately, without a clock edge.
- Fill: set indices 0..7 on consecutive cycles with set_valid=1 -> set_ready=1 each cycle; mask=8'hFF, count=8, full=1 one cycle after the last set. A further set of index 3 -> set_ready=0, mask unchanged.
- Same-cycle set/clear, mask=8'h10: set_index=4 with clear_index=4 -> set_ready=1, mask stays 8'h10, count stays 1. Then set 2 / clear 4 -> mask=8'h04, count=1.
- Flush: mask=8'h3C with clear_all=1 plus a valid set of index 0 -> next mask=0, count=0, empty=1; the set is dropped.
- N=6 non-power-of-two: set_index=7 -> set_ready=0, mask unchanged. Clear of index 6 -> no change. With SCOREBOARD_ERR_CHECK_EN, err=1 next cycle and stays 1 until clear_all.
- Random soak of 10k cycles against a reference model: the count == popcount(mask) and full/empty consistency invariants must hold every cycle.

Source files
------------

// File: rtl/index_scoreboard.sv
// Index-to-bitmap scoreboard: one-hot set/clear of a registered occupancy mask.
// Optional sticky error flag under SCOREBOARD_ERR_CHECK_EN.
module index_scoreboard #(
  parameter int N = 8,
  localparam int LogN = (N == 1) ? 0 : $clog2(N) - 1
) (
  input  logic            clock,
  input  logic            reset_n,
  input  logic            set_valid,
  input  logic [LogN:0]   set_index,
  output logic            set_ready,
  input  logic            clear_valid,
  input  logic [LogN:0]   clear_index,
  input  logic            clear_all,
  output logic [N-1:0]    mask,
  output logic [LogN+1:0] count,
  output logic            full,
  output logic            empty
`ifdef SCOREBOARD_ERR_CHECK_EN
  ,
  output logic            err
`endif
);

  localparam int IW = LogN + 1;
  localparam int CW = LogN + 2;
  localparam logic [IW:0] NV = (IW+1)'(N);

  logic [N-1:0]  mask_q, mask_d;
  logic [CW-1:0] count_q, count_d;
  logic          full_q, full_d;
  logic          empty_q, empty_d;

  logic [N-1:0]  set_oh, clr_oh;
  logic          set_in_rng;
  logic          busy_set, busy_clr;
  logic          same_idx, clear_hit;
  logic          set_fire, set_new, clear_eff;

  always_comb begin
    set_oh = '0;
    clr_oh = '0;
    for (int i = 0; i < N; i++) begin
      set_oh[i] = (set_index == IW'(i));
      clr_oh[i] = (clear_index == IW'(i));
    end
  end

  always_comb begin
    set_in_rng = ({1'b0, set_index} < NV);
    busy_set   = |(mask_q & set_oh);
    busy_clr   = |(mask_q & clr_oh);
    same_idx   = (clear_index == set_index);
    clear_hit  = clear_valid & same_idx;
    set_ready  = set_in_rng & (~busy_set | clear_hit);
    set_fire   = set_valid & set_ready;
    // a re-set of the same slot masks the clear for the count
    set_new    = set_fire & ~busy_set;
    clear_eff  = clear_valid & busy_clr & ~(set_fire & same_idx);
  end

  always_comb begin
    mask_d  = (mask_q & ~(clear_valid ? clr_oh : '0))
            | (set_fire ? set_oh : '0);
    count_d = count_q + CW'(set_new) - CW'(clear_eff);
    if (clear_all) begin
      mask_d  = '0;
      count_d = '0;
    end
    full_d  = (count_d == CW'(N));
    empty_d = (count_d == '0);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      mask_q  <= '0;
      count_q <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
    end else begin
      mask_q  <= mask_d;
      count_q <= count_d;
      full_q  <= full_d;
      empty_q <= empty_d;
    end
  end

  assign mask  = mask_q;
  assign count = count_q;
  assign full  = full_q;
  assign empty = empty_q;

`ifdef SCOREBOARD_ERR_CHECK_EN
  logic err_q, err_d;

  // one-hot of a free or out-of-range index never hits the mask
  always_comb begin
    err_d = err_q
          | (clear_valid & ~busy_clr)
          | (set_valid & ~set_in_rng);
    if (clear_all) err_d = 1'b0;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) err_q <= 1'b0;
    else          err_q <= err_d;
  end

  assign err = err_q;
`endif

endmodule

// File: tb/tb_index_scoreboard.sv
// Bench for index_scoreboard: N=8 and N=6 instances sharing stimulus,
// checked against a bitmap model plus hand-computed literals.
module tb_index_scoreboard;

  logic       clock = 1'b0;
  logic       reset_n;
  logic       set_valid, clear_valid, clear_all;
  logic [2:0] set_index, clear_index;

  logic       set_ready8, set_ready6;
  logic [7:0] mask8;
  logic [5:0] mask6;
  logic [3:0] count8, count6;
  logic       full8, full6, empty8, empty6;
`ifdef SCOREBOARD_ERR_CHECK_EN
  logic       err8, err6;
  logic       e8, e6;
`endif

  int errors = 0;
  int checks = 0;
  logic rdy8, rdy6;
  logic [7:0] m8, m6;

  always #5 clock = ~clock;

  index_scoreboard #(.N(8)) u_dut8 (
    .clock(clock), .reset_n(reset_n),
    .set_valid(set_valid), .set_index(set_index), .set_ready(set_ready8),
    .clear_valid(clear_valid), .clear_index(clear_index),
    .clear_all(clear_all), .mask(mask8), .count(count8),
    .full(full8), .empty(empty8)
`ifdef SCOREBOARD_ERR_CHECK_EN
    , .err(err8)
`endif
  );

  index_scoreboard #(.N(6)) u_dut6 (
    .clock(clock), .reset_n(reset_n),
    .set_valid(set_valid), .set_index(set_index), .set_ready(set_ready6),
    .clear_valid(clear_valid), .clear_index(clear_index),
    .clear_all(clear_all), .mask(mask6), .count(count6),
    .full(full6), .empty(empty6)
`ifdef SCOREBOARD_ERR_CHECK_EN
    , .err(err6)
`endif
  );

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic m_rdy(input logic [7:0] m, input int n,
                                 input logic [2:0] si, input logic cv,
                                 input logic [2:0] ci);
    return (int'(si) < n) && (!m[si] || (cv && ci == si));
  endfunction

  function automatic logic [7:0] m_next(input logic [7:0] m, input int n,
                                        input logic sv, input logic [2:0] si,
                                        input logic cv, input logic [2:0] ci,
                                        input logic ca);
    logic [7:0] r;
    if (ca) return 8'h00;
    r = m;
    if (cv && int'(ci) < n) r[ci] = 1'b0;
    if (sv && m_rdy(m, n, si, cv, ci)) r[si] = 1'b1;
    return r;
  endfunction

  function automatic logic m_err(input logic [7:0] m, input int n,
                                 input logic sv, input logic [2:0] si,
                                 input logic cv, input logic [2:0] ci);
    return (cv && (int'(ci) >= n || !m[ci])) || (sv && int'(si) >= n);
  endfunction

  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      m8 <= '0;
      m6 <= '0;
`ifdef SCOREBOARD_ERR_CHECK_EN
      e8 <= 1'b0;
      e6 <= 1'b0;
`endif
    end else begin
      m8 <= m_next(m8, 8, set_valid, set_index, clear_valid, clear_index,
                   clear_all);
      m6 <= m_next(m6, 6, set_valid, set_index, clear_valid, clear_index,
                   clear_all);
`ifdef SCOREBOARD_ERR_CHECK_EN
      e8 <= clear_all ? 1'b0 : (e8 | m_err(m8, 8, set_valid, set_index,
                                           clear_valid, clear_index));
      e6 <= clear_all ? 1'b0 : (e6 | m_err(m6, 6, set_valid, set_index,
                                           clear_valid, clear_index));
`endif
    end
  end

  always @(negedge clock) begin
    chk("mask8", 32'(mask8), 32'(m8));
    chk("count8", 32'(count8), $countones(m8));
    chk("inv8", 32'(count8), $countones(mask8));
    chk("full8", 32'(full8), 32'($countones(m8) == 8));
    chk("empty8", 32'(empty8), 32'(m8 == 0));
    chk("ready8", 32'(set_ready8),
        32'(m_rdy(m8, 8, set_index, clear_valid, clear_index)));
    chk("mask6", 32'(mask6), 32'(m6));
    chk("count6", 32'(count6), $countones(m6));
    chk("full6", 32'(full6), 32'($countones(m6) == 6));
    chk("empty6", 32'(empty6), 32'(m6 == 0));
    chk("ready6", 32'(set_ready6),
        32'(m_rdy(m6, 6, set_index, clear_valid, clear_index)));
`ifdef SCOREBOARD_ERR_CHECK_EN
    chk("err8", 32'(err8), 32'(e8));
    chk("err6", 32'(err6), 32'(e6));
`endif
  end

  // entered and left at posedge+1; ready sampled before the edge
  task automatic step(input logic sv, input logic [2:0] si, input logic cv,
                      input logic [2:0] ci, input logic ca);
    set_valid   = sv;
    set_index   = si;
    clear_valid = cv;
    clear_index = ci;
    clear_all   = ca;
    #1;
    rdy8 = set_ready8;
    rdy6 = set_ready6;
    @(posedge clock);
    #1;
  endtask

  initial begin
    reset_n = 1'b0;
    set_valid = 0; set_index = 0;
    clear_valid = 0; clear_index = 0; clear_all = 0;
    repeat (2) @(posedge clock);
    #1;
    chk("rst_mask", 32'(mask8), 0);
    chk("rst_count", 32'(count8), 0);
    chk("rst_empty", 32'(empty8), 1);
    chk("rst_full", 32'(full8), 0);
    reset_n = 1'b1;

    for (int i = 0; i < 8; i++) begin
      step(1, 3'(i), 0, 0, 0);
      chk("fill_rdy8", 32'(rdy8), 1);
      chk("fill_rdy6", 32'(rdy6), 32'(i < 6));
    end
    chk("fill_mask", 32'(mask8), 32'h0FF);
    chk("fill_count", 32'(count8), 8);
    chk("fill_full", 32'(full8), 1);
    chk("fill_mask6", 32'(mask6), 32'h3F);
    chk("fill_full6", 32'(full6), 1);
    step(1, 3, 0, 0, 0);
    chk("busy_rdy", 32'(rdy8), 0);
    chk("busy_mask", 32'(mask8), 32'h0FF);

    step(0, 0, 0, 0, 1);
    step(1, 4, 0, 0, 0);
    chk("sc_pre", 32'(mask8), 32'h10);
    step(1, 4, 1, 4, 0);
    chk("sc_rdy", 32'(rdy8), 1);
    chk("sc_mask", 32'(mask8), 32'h10);
    chk("sc_count", 32'(count8), 1);
    step(1, 2, 1, 4, 0);
    chk("sc2_mask", 32'(mask8), 32'h04);
    chk("sc2_count", 32'(count8), 1);

    step(1, 3, 0, 0, 0);
    step(1, 4, 0, 0, 0);
    step(1, 5, 0, 0, 0);
    chk("fl_pre", 32'(mask8), 32'h3C);
    step(1, 0, 0, 0, 1);
    chk("fl_rdy", 32'(rdy8), 1);
    chk("fl_mask", 32'(mask8), 0);
    chk("fl_count", 32'(count8), 0);
    chk("fl_empty", 32'(empty8), 1);

    step(1, 1, 0, 0, 0);
    step(1, 7, 0, 0, 0);
    chk("n6_rdy7", 32'(rdy6), 0);
    chk("n6_mask", 32'(mask6), 32'h02);
    step(0, 0, 1, 6, 0);
    chk("n6_clr6", 32'(mask6), 32'h02);
    chk("n6_count", 32'(count6), 1);
`ifdef SCOREBOARD_ERR_CHECK_EN
    chk("n6_err", 32'(err6), 1);
    step(0, 0, 0, 0, 0);
    chk("n6_err_hold", 32'(err6), 1);
    step(0, 0, 0, 0, 1);
    chk("n6_err_clr", 32'(err6), 0);
`endif

    step(0, 0, 0, 0, 1);
    step(1, 0, 0, 0, 0);
    step(1, 2, 0, 0, 0);
    step(1, 5, 0, 0, 0);
    step(1, 7, 0, 0, 0);
    chk("ar_pre", 32'(mask8), 32'hA5);
    set_valid = 0;
    clear_valid = 0;
    #2;
    reset_n = 1'b0;
    #1;
    chk("ar_mask", 32'(mask8), 0);
    chk("ar_count", 32'(count8), 0);
    chk("ar_empty", 32'(empty8), 1);
    chk("ar_full", 32'(full8), 0);
    @(posedge clock);
    #1;
    reset_n = 1'b1;

    for (int k = 0; k < 10000; k++) begin
      step(1'($urandom_range(0, 3) != 0), 3'($urandom_range(0, 7)),
           1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
           1'($urandom_range(0, 63) == 0));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
